// File: rtl/seg_settings_bank.sv
// rtl/seg_settings_bank.sv - double-buffered per-segment settings store with validated atomic commit.
// Optional shadow readback port (RE/RADDR/RDATA) is built when SETTINGS_READBACK_EN is defined.
module seg_settings_bank #(
  parameter int NUM_SEGMENTS   = 2,
  parameter int CYCLE_WIDTH    = 16,
  parameter int FREQ_DIV_WIDTH = 32,
  parameter int REP_WIDTH      = 32,
  localparam int SEG_W = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 WE,
  input  logic [SEG_W+2:0]                     WADDR,
  input  logic [15:0]                          WDATA,
  input  logic                                 COMMIT,
  input  logic [SEG_W-1:0]                     COMMIT_SEG,
  output logic                                 BUSY,
  output logic                                 UPDATE,
  output logic [SEG_W-1:0]                     REQ_RD_SEGMENT,
  output logic [NUM_SEGMENTS*CYCLE_WIDTH-1:0]    CYCLE,
  output logic [NUM_SEGMENTS*FREQ_DIV_WIDTH-1:0] FREQ_DIV,
  output logic [NUM_SEGMENTS*REP_WIDTH-1:0]      REP,
`ifdef SETTINGS_READBACK_EN
  input  logic                                 RE,
  input  logic [SEG_W+2:0]                     RADDR,
  output logic [15:0]                          RDATA,
`endif
  output logic                                 ERR
);

  // Shadow arrays cover every encodable index so lookups never go out of bounds.
  localparam int NUM_SLOTS = 1 << SEG_W;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COPY, S_PULSE} state_t;

  state_t           state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             err_q;
  logic [SEG_W-1:0] req_q;
  logic             check_ok;

  logic [CYCLE_WIDTH-1:0]    shadow_cycle_q [NUM_SLOTS];
  logic [FREQ_DIV_WIDTH-1:0] shadow_freq_q  [NUM_SLOTS];
  logic [REP_WIDTH-1:0]      shadow_rep_q   [NUM_SLOTS];

  logic [NUM_SEGMENTS*CYCLE_WIDTH-1:0]    active_cycle_q;
  logic [NUM_SEGMENTS*FREQ_DIV_WIDTH-1:0] active_freq_q;
  logic [NUM_SEGMENTS*REP_WIDTH-1:0]      active_rep_q;

  logic [SEG_W-1:0] w_seg;
  logic [2:0]       w_field;
  logic             w_ok;

  assign w_seg   = WADDR[SEG_W+2:3];
  assign w_field = WADDR[2:0];
  assign w_ok    = WE && (int'(w_seg) < NUM_SEGMENTS);

  assign check_ok = (int'(seg_q) < NUM_SEGMENTS) &&
                    (shadow_freq_q[seg_q] != '0) &&
                    (shadow_cycle_q[seg_q] != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    case (state_q)
      S_IDLE: begin
        if (COMMIT) begin
          seg_d   = COMMIT_SEG;
          state_d = S_CHECK;
        end
      end
      S_CHECK: state_d = check_ok ? S_COPY : S_IDLE;
      S_COPY:  state_d = S_PULSE;
      S_PULSE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Host writes land in the shadow regardless of the commit FSM state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_cycle_q[i] <= '0;
        shadow_freq_q[i]  <= FREQ_DIV_WIDTH'(1);
        shadow_rep_q[i]   <= '0;
      end
    end else if (w_ok) begin
      case (w_field)
        3'd0: shadow_cycle_q[w_seg] <= WDATA[CYCLE_WIDTH-1:0];
        3'd1: shadow_freq_q[w_seg][15:0] <= WDATA;
        3'd2: shadow_freq_q[w_seg][FREQ_DIV_WIDTH-1:16] <= WDATA[FREQ_DIV_WIDTH-17:0];
        3'd3: shadow_rep_q[w_seg][15:0] <= WDATA;
        3'd4: shadow_rep_q[w_seg][REP_WIDTH-1:16] <= WDATA[REP_WIDTH-17:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      active_cycle_q <= '0;
      active_rep_q   <= '0;
      for (int k = 0; k < NUM_SEGMENTS; k++) begin
        active_freq_q[k*FREQ_DIV_WIDTH +: FREQ_DIV_WIDTH] <= FREQ_DIV_WIDTH'(1);
      end
      req_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_CHECK && !check_ok) begin
        err_q <= 1'b1;
      end
      if (state_q == S_COPY) begin
        for (int k = 0; k < NUM_SEGMENTS; k++) begin
          if (seg_q == SEG_W'(k)) begin
            active_cycle_q[k*CYCLE_WIDTH +: CYCLE_WIDTH]       <= shadow_cycle_q[k];
            active_freq_q[k*FREQ_DIV_WIDTH +: FREQ_DIV_WIDTH]  <= shadow_freq_q[k];
            active_rep_q[k*REP_WIDTH +: REP_WIDTH]             <= shadow_rep_q[k];
          end
        end
        req_q <= seg_q;
        err_q <= 1'b0;
      end
    end
  end

`ifdef SETTINGS_READBACK_EN
  logic [15:0]      rdata_q;
  logic [SEG_W-1:0] r_seg;
  logic [2:0]       r_field;

  assign r_seg   = RADDR[SEG_W+2:3];
  assign r_field = RADDR[2:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
    end else if (RE) begin
      rdata_q <= '0;
      if (int'(r_seg) < NUM_SEGMENTS) begin
        case (r_field)
          3'd0: rdata_q <= 16'(shadow_cycle_q[r_seg]);
          3'd1: rdata_q <= shadow_freq_q[r_seg][15:0];
          3'd2: rdata_q <= 16'(shadow_freq_q[r_seg][FREQ_DIV_WIDTH-1:16]);
          3'd3: rdata_q <= shadow_rep_q[r_seg][15:0];
          3'd4: rdata_q <= 16'(shadow_rep_q[r_seg][REP_WIDTH-1:16]);
          default: rdata_q <= '0;
        endcase
      end
    end
  end

  assign RDATA = rdata_q;
`endif

  assign BUSY           = (state_q != S_IDLE);
  assign UPDATE         = (state_q == S_PULSE);
  assign REQ_RD_SEGMENT = req_q;
  assign CYCLE          = active_cycle_q;
  assign FREQ_DIV       = active_freq_q;
  assign REP            = active_rep_q;
  assign ERR            = err_q;

endmodule
